// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings between the Control decoder and the hazard/exception sequencer.
package cpu_ctrl_pkg;

  localparam logic [2:0] PCSRC_NONE = 3'd0;
  localparam logic [2:0] PCSRC_IRQ  = 3'd4;
  localparam logic [2:0] PCSRC_EXC  = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_HOLD     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/hazard_exc_sequencer_if.sv
// Pipeline-side hazard/exception bundle; master is the pipeline, slave is the sequencer.
interface hazard_exc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_undef;
  logic             ex_memrd;
  logic [4:0]       ex_wr_reg;
  logic             ex_is_branch;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             irq;
  logic             pc31;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exc_take;
  logic [2:0]       pcsrc_ovr;
  logic             irq_pending;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_undef,
           ex_memrd, ex_wr_reg, ex_is_branch, ex_br_taken,
           mem_busy, irq, pc31,
    input  pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
           exc_take, pcsrc_ovr, irq_pending, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_undef,
           ex_memrd, ex_wr_reg, ex_is_branch, ex_br_taken,
           mem_busy, irq, pc31,
    output pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
           exc_take, pcsrc_ovr, irq_pending, stall_cnt
  );
endinterface

// File: rtl/hazard_exc_sequencer_load_use_detect.sv
// Load-use hazard: EX load writes a register the ID instruction reads ($zero never hazards).
module load_use_detect (
  input  logic       ex_memrd,
  input  logic [4:0] ex_wr_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu
);
  assign lu = ex_memrd && (ex_wr_reg != 5'd0) &&
              ((ex_wr_reg == id_rs) || (id_uses_rt && (ex_wr_reg == id_rt)));
endmodule

// File: rtl/hazard_exc_sequencer.sv
// Stall/flush/trap sequencer for the 5-stage pipeline: load-use, memory freeze, branch flush,
// IRQ latching and exception/interrupt entry with a post-take blackout window.
module hazard_exc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int BLACKOUT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_exc_sequencer_if.slave  bus
);

  localparam int BW = (BLACKOUT < 2) ? 1 : $clog2(BLACKOUT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  seq_state_e       state, state_nxt;
  logic [BW-1:0]    blk_cnt, blk_nxt;
  logic             irq_pending, irq_pending_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;

  logic pc_stall_c, ifid_stall_c, idex_stall_c, ifid_flush_c, idex_flush_c;
  logic take_exc, take_irq;

  load_use_detect u_lu (
    .ex_memrd   (bus.ex_memrd),
    .ex_wr_reg  (bus.ex_wr_reg),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .lu         (lu)
  );

  always_comb begin
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    idex_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    take_exc     = 1'b0;
    take_irq     = 1'b0;
    state_nxt    = state;
    blk_nxt      = blk_cnt;

    if (bus.mem_busy) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_stall_c = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (blk_cnt != '0) blk_nxt = blk_cnt - 1'b1;
          if (blk_cnt <= BW'(1)) state_nxt = ST_RUN;
        end
        ST_LU_STALL: state_nxt = ST_RUN;
        default: ;
      endcase

      if (bus.ex_br_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (bus.id_valid && bus.id_undef && !bus.pc31 && state != ST_HOLD) begin
        take_exc     = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (lu) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_flush_c = 1'b1;
        // A load-use bubble inside the blackout must not cut the blackout short.
        if (state != ST_HOLD) state_nxt = ST_LU_STALL;
      end else if (irq_pending && !bus.pc31 && bus.id_valid && !bus.ex_is_branch &&
                   state == ST_RUN) begin
        take_irq     = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end

      if (take_exc || take_irq) begin
        state_nxt = ST_HOLD;
        blk_nxt   = BW'(BLACKOUT);
      end
    end
  end

  // Kernel-mode requests are dropped, not latched; the take edge clears the latch.
  assign irq_pending_nxt = take_irq ? 1'b0 : (irq_pending || (bus.irq && !bus.pc31));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      blk_cnt     <= '0;
      irq_pending <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      blk_cnt     <= blk_nxt;
      irq_pending <= irq_pending_nxt;
      if (pc_stall_c) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  assign bus.pc_stall    = pc_stall_c   && !reset;
  assign bus.ifid_stall  = ifid_stall_c && !reset;
  assign bus.idex_stall  = idex_stall_c && !reset;
  assign bus.ifid_flush  = ifid_flush_c && !reset;
  assign bus.idex_flush  = idex_flush_c && !reset;
  assign bus.exc_take    = (take_exc || take_irq) && !reset;
  assign bus.pcsrc_ovr   = reset    ? PCSRC_NONE :
                           take_exc ? PCSRC_EXC  :
                           take_irq ? PCSRC_IRQ  : PCSRC_NONE;
  assign bus.irq_pending = irq_pending;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_hazard_exc_sequencer.sv
// Directed bench for hazard_exc_sequencer; small CNT_W so counter saturation is reachable.
module tb_hazard_exc_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  hazard_exc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  hazard_exc_sequencer #(.BLACKOUT(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid     = 1'b1;
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_uses_rt   = 1'b0;
    bus.id_undef     = 1'b0;
    bus.ex_memrd     = 1'b0;
    bus.ex_wr_reg    = 5'd0;
    bus.ex_is_branch = 1'b0;
    bus.ex_br_taken  = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.irq          = 1'b0;
    bus.pc31         = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    bus.ex_memrd  = 1'b1;
    bus.ex_wr_reg = r;
    bus.id_rs     = r;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_pending", 32'(bus.irq_pending), 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst_pc_stall", 32'(bus.pc_stall), 0);
    check("rst_pcsrc", 32'(bus.pcsrc_ovr), 0);
    reset = 1'b0;

    // load-use on rs
    set_lu(5'd4);
    #1;
    check("lu_pc_stall", 32'(bus.pc_stall), 1);
    check("lu_ifid_stall", 32'(bus.ifid_stall), 1);
    check("lu_idex_flush", 32'(bus.idex_flush), 1);
    check("lu_idex_stall", 32'(bus.idex_stall), 0);
    check("lu_no_take", 32'(bus.exc_take), 0);
    tick();
    idle_inputs();
    #1;
    check("lu_cnt1", 32'(bus.stall_cnt), 1);
    check("lu_one_cycle", 32'(bus.pc_stall), 0);
    tick();

    // $zero and rt-path cases
    bus.ex_memrd = 1'b1;
    #1;
    check("zero_no_stall", 32'(bus.pc_stall), 0);
    bus.ex_wr_reg  = 5'd7;
    bus.id_rt      = 5'd7;
    bus.id_rs      = 5'd3;
    bus.id_uses_rt = 1'b1;
    #1;
    check("rt_stall", 32'(bus.pc_stall), 1);
    bus.id_uses_rt = 1'b0;
    #1;
    check("rt_unused_no_stall", 32'(bus.pc_stall), 0);
    bus.id_uses_rt = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("rt_cnt2", 32'(bus.stall_cnt), 2);
    tick();

    // irq pulse, take, blackout, then exception
    bus.irq = 1'b1;
    #1;
    check("irq_not_yet", 32'(bus.irq_pending), 0);
    tick();
    bus.irq = 1'b0;
    #1;
    check("irq_latched", 32'(bus.irq_pending), 1);
    check("irq_take", 32'(bus.exc_take), 1);
    check("irq_pcsrc", 32'(bus.pcsrc_ovr), 32'(PCSRC_IRQ));
    check("irq_ifid_flush", 32'(bus.ifid_flush), 1);
    tick();
    check("irq_cleared", 32'(bus.irq_pending), 0);
    bus.id_undef = 1'b1;
    #1;
    check("hold1_no_take", 32'(bus.exc_take), 0);
    tick();
    check("hold2_no_take", 32'(bus.exc_take), 0);
    tick();
    check("exc_take", 32'(bus.exc_take), 1);
    check("exc_pcsrc", 32'(bus.pcsrc_ovr), 32'(PCSRC_EXC));
    bus.id_undef = 1'b0;
    repeat (3) tick();

    // irq deferred by branch shadow
    bus.irq          = 1'b1;
    bus.ex_is_branch = 1'b1;
    tick();
    bus.irq = 1'b0;
    #1;
    check("shadow_no_take", 32'(bus.exc_take), 0);
    check("shadow_pending", 32'(bus.irq_pending), 1);
    tick();
    bus.ex_is_branch = 1'b0;
    #1;
    check("shadow_late_take", 32'(bus.exc_take), 1);
    check("shadow_pcsrc", 32'(bus.pcsrc_ovr), 32'(PCSRC_IRQ));
    repeat (3) tick();

    // taken branch concurrent with pending irq
    bus.irq = 1'b1;
    tick();
    bus.irq          = 1'b0;
    bus.ex_br_taken  = 1'b1;
    bus.ex_is_branch = 1'b1;
    #1;
    check("br_ifid_flush", 32'(bus.ifid_flush), 1);
    check("br_idex_flush", 32'(bus.idex_flush), 1);
    check("br_no_take", 32'(bus.exc_take), 0);
    tick();
    bus.ex_br_taken  = 1'b0;
    bus.ex_is_branch = 1'b0;
    #1;
    check("br_then_take", 32'(bus.exc_take), 1);
    check("br_then_pcsrc", 32'(bus.pcsrc_ovr), 32'(PCSRC_IRQ));
    repeat (3) tick();

    // kernel mode: no trap, no latch
    bus.pc31     = 1'b1;
    bus.id_undef = 1'b1;
    bus.irq      = 1'b1;
    #1;
    check("kern_no_take", 32'(bus.exc_take), 0);
    check("kern_pcsrc", 32'(bus.pcsrc_ovr), 0);
    tick();
    check("kern_no_latch", 32'(bus.irq_pending), 0);
    idle_inputs();
    tick();

    // memory freeze over load-use and pending irq, with saturation
    bus.irq = 1'b1;
    tick();
    bus.irq      = 1'b0;
    bus.mem_busy = 1'b1;
    set_lu(5'd4);
    #1;
    check("busy_pc_stall", 32'(bus.pc_stall), 1);
    check("busy_idex_stall", 32'(bus.idex_stall), 1);
    check("busy_no_ifid_flush", 32'(bus.ifid_flush), 0);
    check("busy_no_idex_flush", 32'(bus.idex_flush), 0);
    check("busy_no_take", 32'(bus.exc_take), 0);
    repeat (6) tick();
    check("cnt_saturated", 32'(bus.stall_cnt), 7);
    check("busy_pending_kept", 32'(bus.irq_pending), 1);
    idle_inputs();
    #1;
    check("after_busy_take", 32'(bus.exc_take), 1);
    tick();
    bus.irq = 1'b1;
    tick();
    bus.irq = 1'b0;
    check("hold_pending_again", 32'(bus.irq_pending), 1);
    set_lu(5'd9);
    bus.id_undef = 1'b1;
    #1;
    check("hold_lu_stall", 32'(bus.pc_stall), 1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_pc_stall", 32'(bus.pc_stall), 0);
    check("arst_idex_flush", 32'(bus.idex_flush), 0);
    check("arst_take", 32'(bus.exc_take), 0);
    check("arst_pcsrc", 32'(bus.pcsrc_ovr), 0);
    check("arst_pending_lost", 32'(bus.irq_pending), 0);
    check("arst_stall_cnt", 32'(bus.stall_cnt), 0);
    tick();
    reset = 1'b0;
    idle_inputs();
    bus.id_undef = 1'b1;
    #1;
    check("post_rst_run_take", 32'(bus.exc_take), 1);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
